alu: RTL and testbench

32-bit integer ALU for the RISC-V datapath execute stage. It computes one of ten RV32I arithmetic, logic, shift or compare operations on two 32-bit operands and produces a result plus four condition flags. Outputs are registered, giving one cycle of latency. The branch unit consumes the flags; writeback consumes the result.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_addsub.sv | 27 ++
 rtl/alu.sv | 108 ++++++++++
 tb/tb_alu.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I execute-stage ALU: data width, opcode map,
// flag bit positions and a legality helper used by the err logic.
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= ALU_SLTU;
  endfunction

  function automatic logic needs_sub(input logic [3:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared 33-bit adder/subtractor: a + (sub ? ~b : b) + sub, with carry-out
// and two's-complement overflow of the operation actually performed.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              carry,
  output logic              overflow
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   full;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
  assign sum   = full[DATA_W-1:0];
  assign carry = full[DATA_W];

  // Overflow is judged against the inverted b on subtract, which turns the
  // "operand signs differ" subtract rule into the same-sign add rule.
  assign overflow = (a[DATA_W-1] == b_eff[DATA_W-1]) &&
                    (sum[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/alu.sv
// Registered 32-bit RV32I ALU (one cycle latency) with {V,C,N,Z} flags.
// Define ALU_ILLEGAL_OP_EN to report opcodes 1010-1111 on err; otherwise err is 0.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        ALUcontrol,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags,
  output logic              valid_out,
  output logic              err
);

  logic [DATA_W-1:0] sum;
  logic              carry;
  logic              overflow;
  logic              sub;
  logic [4:0]        shamt;

  logic [DATA_W-1:0] result_next;
  logic              c_next;
  logic              v_next;
  logic [3:0]        flags_next;

  assign sub   = needs_sub(ALUcontrol);
  assign shamt = B[4:0];

  alu_addsub u_addsub (
    .a        (A),
    .b        (B),
    .sub      (sub),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    result_next = '0;
    c_next      = 1'b0;
    v_next      = 1'b0;
    case (ALUcontrol)
      ALU_ADD, ALU_SUB: begin
        result_next = sum;
        c_next      = carry;
        v_next      = overflow;
      end
      ALU_AND: result_next = A & B;
      ALU_OR:  result_next = A | B;
      ALU_XOR: result_next = A ^ B;
      ALU_SLT: begin
        // Signed less-than comes from the subtraction, not the final result.
        result_next = {{(DATA_W-1){1'b0}}, sum[DATA_W-1] ^ overflow};
        c_next      = carry;
        v_next      = overflow;
      end
      ALU_SLTU: begin
        result_next = {{(DATA_W-1){1'b0}}, ~carry};
        c_next      = carry;
        v_next      = overflow;
      end
      ALU_SLL: result_next = A << shamt;
      ALU_SRL: result_next = A >> shamt;
      ALU_SRA: result_next = $unsigned($signed(A) >>> shamt);
      default: result_next = '0;
    endcase

    flags_next         = '0;
    flags_next[FLAG_V] = v_next;
    flags_next[FLAG_C] = c_next;
    flags_next[FLAG_N] = result_next[DATA_W-1];
    flags_next[FLAG_Z] = (result_next == '0);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      flags     <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        result <= result_next;
        flags  <= flags_next;
      end
    end
  end

`ifdef ALU_ILLEGAL_OP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (valid_in) begin
      err <= ~is_legal_op(ALUcontrol);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed table, hold/reset sequences, and
// randomized traffic against an arithmetic reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] A, B;
  logic [3:0]  ALUcontrol;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        valid_out;
  logic        err;

  int compared   = 0;
  int mismatched = 0;

  alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .A          (A),
    .B          (B),
    .ALUcontrol (ALUcontrol),
    .result     (result),
    .flags      (flags),
    .valid_out  (valid_out),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [3:0]  exp_flags;
  } vec_t;

  localparam longint SMAX = 64'sh7fffffff;
  localparam longint SMIN = -64'sh80000000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic exp_err(input logic [3:0] op);
`ifdef ALU_ILLEGAL_OP_EN
    return op > 4'd9;
`else
    return 1'b0 & op[0];
`endif
  endfunction

  // Reference model: plain 64-bit arithmetic from the opcode definitions.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    int              sh = int'(b[4:0]);
    logic            c = 1'b0;
    logic            v = 1'b0;
    r = 32'h0;
    case (op)
      4'd0: begin
        r = 32'(ua + ub);
        c = (ua + ub) > 64'hffffffff;
        v = (sa + sb) > SMAX || (sa + sb) < SMIN;
      end
      4'd1, 4'd5, 4'd9: begin
        c = ua >= ub;
        v = (sa - sb) > SMAX || (sa - sb) < SMIN;
        if (op == 4'd1)      r = 32'(ua - ub);
        else if (op == 4'd5) r = (sa < sb) ? 32'd1 : 32'd0;
        else                 r = (ua < ub) ? 32'd1 : 32'd0;
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd6: r = 32'(ua * (64'd1 << sh));
      4'd7: r = 32'(ua / (64'd1 << sh));
      4'd8: r = 32'(sa >>> sh);
      default: r = 32'h0;
    endcase
    f = {v, c, r[31], (r == 32'h0)};
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid_in   = v;
    ALUcontrol = op;
    A          = a;
    B          = b;
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs [15];
  logic [31:0] m_res;
  logic [3:0]  m_flags;
  logic        m_err;
  logic [31:0] r_tmp;
  logic [3:0]  f_tmp;

  initial begin
    vecs[0]  = '{4'd0, 32'h00000002, 32'h00000001, 32'h00000003, 4'b0000};
    vecs[1]  = '{4'd1, 32'h00000002, 32'h00000001, 32'h00000001, 4'b0100};
    vecs[2]  = '{4'd1, 32'h00000001, 32'h00000002, 32'hffffffff, 4'b0010};
    vecs[3]  = '{4'd2, 32'hffffffff, 32'h00000002, 32'h00000002, 4'b0000};
    vecs[4]  = '{4'd3, 32'h00000002, 32'h00000001, 32'h00000003, 4'b0000};
    vecs[5]  = '{4'd4, 32'h55555555, 32'haaaaaaaa, 32'hffffffff, 4'b0010};
    vecs[6]  = '{4'd5, 32'h00000001, 32'h00000002, 32'h00000001, 4'b0000};
    vecs[7]  = '{4'd5, 32'h7fffffff, 32'h80000000, 32'h00000000, 4'b1001};
    vecs[8]  = '{4'd9, 32'h7fffffff, 32'h80000000, 32'h00000001, 4'b1000};
    vecs[9]  = '{4'd9, 32'h80000000, 32'h7fffffff, 32'h00000000, 4'b1101};
    vecs[10] = '{4'd6, 32'h55555555, 32'h00000001, 32'haaaaaaaa, 4'b0010};
    vecs[11] = '{4'd7, 32'hbbbbbbbb, 32'h00000001, 32'h5ddddddd, 4'b0000};
    vecs[12] = '{4'd8, 32'hfffffffe, 32'h00000001, 32'hffffffff, 4'b0010};
    vecs[13] = '{4'd15, 32'h12345678, 32'h9abcdef0, 32'h00000000, 4'b0001};
    vecs[14] = '{4'd6, 32'h80000001, 32'hffffffe0, 32'h80000001, 4'b0010};

    rst_n = 1'b0; valid_in = 1'b0; ALUcontrol = 4'd0; A = '0; B = '0;
    #12;
    check("reset_result", result, 32'h0);
    check("reset_flags", 32'(flags), 32'h0);
    check("reset_valid", 32'(valid_out), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      check($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].exp_flags));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(exp_err(vecs[i].op)));
      check($sformatf("vec%0d_valid", i), 32'(valid_out), 32'h1);
    end

    // Hold: valid_in low keeps the last capture and drops valid_out.
    drive(1'b1, 4'd0, 32'h00000002, 32'h00000001);
    drive(1'b0, 4'd1, 32'h00000001, 32'h00000002);
    drive(1'b0, 4'd15, 32'hdeadbeef, 32'h0);
    check("hold_result", result, 32'h3);
    check("hold_flags", 32'(flags), 32'h0);
    check("hold_valid", 32'(valid_out), 32'h0);
    check("hold_err", 32'(err), 32'h0);

    // Illegal opcode then hold keeps err.
    drive(1'b1, 4'd12, 32'h1, 32'h1);
    drive(1'b0, 4'd0, 32'h1, 32'h1);
    check("illegal_hold_err", 32'(err), 32'(exp_err(4'd12)));
    check("illegal_hold_flags", 32'(flags), 32'h1);

    // Asynchronous reset mid-stream clears everything without a clock edge.
    drive(1'b1, 4'd1, 32'h00000001, 32'h00000002);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_result", result, 32'h0);
    check("midrst_flags", 32'(flags), 32'h0);
    check("midrst_valid", 32'(valid_out), 32'h0);
    check("midrst_err", 32'(err), 32'h0);
    valid_in = 1'b1; ALUcontrol = 4'd15;
    @(posedge clk); #1;
    check("rst_held_result", result, 32'h0);
    check("rst_held_err", 32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'd4, 32'hf0f0f0f0, 32'h0f0f0f0f);
    check("post_rst_result", result, 32'hffffffff);
    check("post_rst_valid", 32'(valid_out), 32'h1);

    // Randomized traffic with a running model of the held outputs.
    m_res = result; m_flags = flags; m_err = err;
    for (int n = 0; n < 400; n++) begin
      logic        v;
      logic [3:0]  op;
      logic [31:0] a, b;
      v  = ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0:       a = 32'h7fffffff;
        1:       a = 32'h80000000;
        2:       a = 32'hffffffff;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = a;
        1:       b = 32'h80000000;
        2:       b = 32'h0;
        default: b = $urandom;
      endcase
      drive(v, op, a, b);
      if (v) begin
        model(op, a, b, r_tmp, f_tmp);
        m_res = r_tmp; m_flags = f_tmp; m_err = exp_err(op);
      end
      check($sformatf("rnd%0d_op%0d_result", n, op), result, m_res);
      check($sformatf("rnd%0d_op%0d_flags", n, op), 32'(flags), 32'(m_flags));
      check($sformatf("rnd%0d_err", n), 32'(err), 32'(m_err));
      check($sformatf("rnd%0d_valid", n), 32'(valid_out), 32'(v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
